// File: rtl/melody_pkg.sv
// melody_pkg: shared state encoding, note entry layout, pitch table and amplitude constants
// for melody_sequencer. A pitch code of 0, and any code without a table entry, is a rest
// (divider 0).
package melody_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // One ROM entry: pitch code in the upper five bits, length in beats below it.
  typedef struct packed {
    logic [4:0] pitch;
    logic [2:0] len;
  } note_t;

  localparam logic [4:0] P_REST = 5'd0;
  localparam logic [4:0] P_C4   = 5'd1;
  localparam logic [4:0] P_D4   = 5'd2;
  localparam logic [4:0] P_E4   = 5'd3;
  localparam logic [4:0] P_F4   = 5'd4;
  localparam logic [4:0] P_G4   = 5'd5;
  localparam logic [4:0] P_A4   = 5'd6;
  localparam logic [4:0] P_B4   = 5'd7;
  localparam logic [4:0] P_C5   = 5'd8;
  localparam logic [4:0] P_D5   = 5'd9;
  localparam logic [4:0] P_E5   = 5'd10;
  localparam logic [4:0] P_F5   = 5'd11;
  localparam logic [4:0] P_G5   = 5'd12;
  localparam logic [4:0] P_A5   = 5'd13;
  localparam logic [4:0] P_B5   = 5'd14;
  localparam logic [4:0] P_C6   = 5'd15;

  // Amplitude of silence for buzzer_control; one volume level adds one step.
  localparam logic [15:0] VOL_SILENCE = 16'h8000;
  localparam logic [15:0] VOL_STEP    = 16'h1000;
  localparam logic [2:0]  VOL_RESET   = 3'd4;
  localparam logic [2:0]  VOL_MAX     = 3'd7;
  localparam logic [2:0]  VOL_MIN     = 3'd0;

  // Divider = 100 MHz / note frequency, rounded.
  function automatic logic [19:0] pitch_div(input logic [4:0] code);
    logic [19:0] div;
    case (code)
      P_C4:    div = 20'd382219;
      P_D4:    div = 20'd340530;
      P_E4:    div = 20'd303370;
      P_F4:    div = 20'd286344;
      P_G4:    div = 20'd255102;
      P_A4:    div = 20'd227273;
      P_B4:    div = 20'd202478;
      P_C5:    div = 20'd191113;
      P_D5:    div = 20'd170262;
      P_E5:    div = 20'd151688;
      P_F5:    div = 20'd143172;
      P_G5:    div = 20'd127553;
      P_A5:    div = 20'd113636;
      P_B5:    div = 20'd101238;
      P_C6:    div = 20'd95557;
      default: div = 20'd0;
    endcase
    return div;
  endfunction

  function automatic logic [15:0] amplitude(input logic [2:0] level);
    return VOL_SILENCE + (16'(level) * VOL_STEP);
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Purpose: song storage, 6-bit address to one 8-bit note entry (pitch code, beat length).
// Latency: combinational.
// Backpressure: none; the entry is always valid for the presented address.
module melody_rom
  import melody_pkg::*;
(
  input  logic [5:0] addr_i,
  output logic [7:0] entry_o
);

  // Song table; the first three entries form a short pitch / rest / zero-length phrase.
  always_comb begin
    entry_o = {P_REST, 3'd1};
    case (addr_i)
      6'd0:    entry_o = {P_C4,   3'd2};
      6'd1:    entry_o = {P_REST, 3'd1};
      6'd2:    entry_o = {P_E4,   3'd0};
      6'd3:    entry_o = {P_C4,   3'd1};
      6'd4:    entry_o = {P_C4,   3'd1};
      6'd5:    entry_o = {P_G4,   3'd1};
      6'd6:    entry_o = {P_G4,   3'd1};
      6'd7:    entry_o = {P_A4,   3'd1};
      6'd8:    entry_o = {P_A4,   3'd1};
      6'd9:    entry_o = {P_G4,   3'd2};
      6'd10:   entry_o = {P_F4,   3'd1};
      6'd11:   entry_o = {P_F4,   3'd1};
      6'd12:   entry_o = {P_E4,   3'd1};
      6'd13:   entry_o = {P_E4,   3'd1};
      6'd14:   entry_o = {P_D4,   3'd1};
      6'd15:   entry_o = {P_D4,   3'd1};
      6'd16:   entry_o = {P_C4,   3'd2};
      6'd17:   entry_o = {P_REST, 3'd2};
      6'd18:   entry_o = {P_C5,   3'd1};
      6'd19:   entry_o = {P_E5,   3'd1};
      6'd20:   entry_o = {P_G5,   3'd1};
      6'd21:   entry_o = {P_C6,   3'd4};
      default: entry_o = {P_REST, 3'd1};
    endcase
  end

endmodule

// File: rtl/melody_sequencer.sv
// Purpose: steps through melody_rom at a fixed beat rate, driving note_div/volumn for buzzer_control.
// Latency: play/volume pulse -> note_div/volumn 2 cycles; beat tick -> note_idx 1 cycle; outputs registered.
// Backpressure: none; pulses act when seen. MELODY_LOOP_EN: wrap to note 0 and keep playing at song end.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int BEAT_DIV = 12_500_000,
  parameter int SONG_LEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play,
  input  logic        stop,
  input  logic        vol_up,
  input  logic        vol_down,
  output logic [19:0] note_div,
  output logic [15:0] volumn,
  output logic [5:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam int             BW        = $clog2(BEAT_DIV);
  localparam logic [BW-1:0]  BEAT_LAST = BW'(BEAT_DIV - 1);
  localparam logic [5:0]     LAST_IDX  = 6'(SONG_LEN - 1);

`ifdef MELODY_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [2:0]    len_q, len_d;
  logic [5:0]    idx_q, idx_d;
  logic [2:0]    level_q, level_d;
  logic [19:0]   note_div_q, note_div_d;
  logic [15:0]   volumn_q, volumn_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [7:0]    rom_dat;
  note_t         cur_note;
  logic [2:0]    cur_len;
  logic [19:0]   cur_div;
  logic          play_run;
  logic          beat_wrap;
  logic          note_last;
  logic          song_end;

  melody_rom u_rom (
    .addr_i  (idx_q),
    .entry_o (rom_dat)
  );

  assign cur_note  = note_t'(rom_dat);
  assign cur_len   = (cur_note.len == 3'd0) ? 3'd1 : cur_note.len;
  assign cur_div   = pitch_div(cur_note.pitch);

  // Counters only advance in a PLAY cycle that is not being paused or stopped.
  assign play_run  = (state_q == ST_PLAY) && !play && !stop;
  assign beat_wrap = play_run && (beat_q == BEAT_LAST);
  assign note_last = (len_q == (cur_len - 3'd1));
  assign song_end  = beat_wrap && note_last && (idx_q == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: stop overrides everything, play starts or toggles pause.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (play) state_d = ST_PLAY;
        ST_PLAY: begin
          if (play) begin
            state_d = ST_PAUSE;
          end else if (song_end && !LOOP_EN) begin
            state_d = ST_IDLE;
          end
        end
        ST_PAUSE: if (play) state_d = ST_PLAY;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs and datapath next values: beat/length counters, note index, volume level.
  always_comb begin
    beat_d     = beat_q;
    len_d      = len_q;
    idx_d      = idx_q;
    level_d    = level_q;
    note_div_d = note_div_q;
    volumn_d   = VOL_SILENCE;
    busy_d     = (state_d != ST_IDLE);
    done_d     = song_end;

    if (stop || ((state_q == ST_IDLE) && play)) begin
      beat_d = '0;
      len_d  = '0;
      idx_d  = '0;
    end else if (play_run) begin
      if (beat_wrap) begin
        beat_d = '0;
        if (note_last) begin
          len_d = '0;
          idx_d = (idx_q == LAST_IDX) ? 6'd0 : idx_q + 6'd1;
        end else begin
          len_d = len_q + 3'd1;
        end
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end

    if (vol_up && !vol_down && (level_q != VOL_MAX)) begin
      level_d = level_q + 3'd1;
    end else if (vol_down && !vol_up && (level_q != VOL_MIN)) begin
      level_d = level_q - 3'd1;
    end

    // Pitch follows the current entry only while playing; rests, IDLE and PAUSE are silent.
    if (state_q == ST_PLAY) begin
      note_div_d = cur_div;
      if (cur_div != 20'd0) begin
        volumn_d = amplitude(level_q);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      level_q    <= VOL_RESET;
      note_div_q <= '0;
      volumn_q   <= VOL_SILENCE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      beat_q     <= beat_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      level_q    <= level_d;
      note_div_q <= note_div_d;
      volumn_q   <= volumn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign note_div = note_div_q;
  assign volumn   = volumn_q;
  assign note_idx = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer with BEAT_DIV=4, SONG_LEN=3 (phrase: C4 x2 beats, rest x1, E4 x0->1).
// Directed timing scenarios followed by random pulses checked against a note-duration model.
// Expectations for song end follow MELODY_LOOP_EN when it is defined for the build.
module tb_melody_sequencer;

  localparam int BD  = 4;
  localparam int LEN = 3;
  localparam logic [19:0] DIV1 = 20'd382219;
  localparam logic [19:0] DIV3 = 20'd303370;

`ifdef MELODY_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        play, stop, vol_up, vol_down;
  logic [19:0] note_div;
  logic [15:0] volumn;
  logic [5:0]  note_idx;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Song phrase as the bench understands it.
  int rom_code [LEN] = '{1, 0, 3};
  int rom_len  [LEN] = '{2, 1, 0};

  melody_sequencer #(.BEAT_DIV(BD), .SONG_LEN(LEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .play     (play),
    .stop     (stop),
    .vol_up   (vol_up),
    .vol_down (vol_down),
    .note_div (note_div),
    .volumn   (volumn),
    .note_idx (note_idx),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  function automatic logic [19:0] div_of(input int code);
    if (code == 1) return DIV1;
    if (code == 3) return DIV3;
    return 20'd0;
  endfunction

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    play = 0; stop = 0; vol_up = 0; vol_down = 0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) cyc();
    #3 rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (note_div !== 20'd0) begin errors++; $display("FAIL reset_note_div got %h want 0", note_div); end
    checks++; if (volumn !== 16'h8000) begin errors++; $display("FAIL reset_volumn got %h want 8000", volumn); end
    checks++; if (note_idx !== 6'd0) begin errors++; $display("FAIL reset_note_idx got %0d want 0", note_idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  // Whole phrase from a play pulse at cycle 10; k counts cycles after the pulse.
  task automatic test_song();
    logic [19:0] e_div;
    logic [15:0] e_vol;
    logic [5:0]  e_idx;
    logic        e_busy, e_done;
    do_reset();
    repeat (9) cyc();
    play = 1; cyc(); play = 0;
    for (int k = 1; k <= 18; k++) begin
      e_idx  = (k <= 8) ? 6'd0 : (k <= 12) ? 6'd1 : (k <= 16) ? 6'd2 : 6'd0;
      e_busy = LOOP ? 1'b1 : (k <= 16);
      e_done = (k == 17);
      if (k == 1)                 begin e_div = 20'd0; e_vol = 16'h8000; end
      else if (k <= 9)            begin e_div = DIV1;  e_vol = 16'hC000; end
      else if (k <= 13)           begin e_div = 20'd0; e_vol = 16'h8000; end
      else if (k <= 17)           begin e_div = DIV3;  e_vol = 16'hC000; end
      else if (LOOP)              begin e_div = DIV1;  e_vol = 16'hC000; end
      else                        begin e_div = DIV3;  e_vol = 16'h8000; end
      checks++; if (note_idx !== e_idx) begin errors++; $display("FAIL song_idx k=%0d got %0d want %0d", k, note_idx, e_idx); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL song_busy k=%0d got %b want %b", k, busy, e_busy); end
      checks++; if (done !== e_done) begin errors++; $display("FAIL song_done k=%0d got %b want %b", k, done, e_done); end
      checks++; if (note_div !== e_div) begin errors++; $display("FAIL song_div k=%0d got %0d want %0d", k, note_div, e_div); end
      checks++; if (volumn !== e_vol) begin errors++; $display("FAIL song_vol k=%0d got %h want %h", k, volumn, e_vol); end
      cyc();
    end
  endtask

  // Pause at beat count 2 of note 0, hold 20 cycles, resume; 6 play cycles remain.
  task automatic test_pause();
    do_reset();
    play = 1; cyc(); play = 0;
    cyc(); cyc();
    play = 1; cyc(); play = 0;
    cyc();
    for (int i = 0; i < 19; i++) begin
      checks++; if (volumn !== 16'h8000) begin errors++; $display("FAIL pause_vol i=%0d got %h want 8000", i, volumn); end
      checks++; if (note_idx !== 6'd0 || busy !== 1'b1) begin
        errors++; $display("FAIL pause_hold i=%0d got idx %0d busy %b want idx 0 busy 1", i, note_idx, busy);
      end
      if (i < 18) cyc();
    end
    play = 1; cyc(); play = 0;
    cyc();
    checks++; if (volumn !== 16'hC000) begin errors++; $display("FAIL resume_vol got %h want c000", volumn); end
    repeat (4) cyc();
    checks++; if (note_idx !== 6'd0) begin errors++; $display("FAIL resume_last_cycle got %0d want 0", note_idx); end
    cyc();
    checks++; if (note_idx !== 6'd1) begin errors++; $display("FAIL resume_advance got %0d want 1", note_idx); end
  endtask

  task automatic test_volume();
    do_reset();
    vol_up = 1; repeat (5) cyc(); vol_up = 0;
    play = 1; cyc(); play = 0;
    cyc();
    checks++; if (volumn !== 16'hF000) begin errors++; $display("FAIL vol_sat_up got %h want f000", volumn); end
    vol_down = 1; cyc(); vol_down = 0;
    checks++; if (volumn !== 16'hF000) begin errors++; $display("FAIL vol_latency1 got %h want f000", volumn); end
    cyc();
    checks++; if (volumn !== 16'hE000) begin errors++; $display("FAIL vol_latency2 got %h want e000", volumn); end
    stop = 1; cyc(); stop = 0;
    vol_down = 1; repeat (9) cyc(); vol_down = 0;
    play = 1; cyc(); play = 0;
    cyc();
    checks++; if (volumn !== 16'h8000 || busy !== 1'b1) begin
      errors++; $display("FAIL vol_sat_down got %h busy %b want 8000 busy 1", volumn, busy);
    end
    vol_up = 1; cyc();
    vol_down = 1; cyc(); vol_up = 0; vol_down = 0;
    checks++; if (volumn !== 16'h9000) begin errors++; $display("FAIL vol_step_up got %h want 9000", volumn); end
    cyc();
    checks++; if (volumn !== 16'h9000) begin errors++; $display("FAIL vol_both got %h want 9000", volumn); end
  endtask

  task automatic test_stop_play();
    do_reset();
    play = 1; cyc(); play = 0;
    repeat (3) cyc();
    stop = 1; play = 1; cyc(); stop = 0; play = 0;
    checks++; if (busy !== 1'b0 || note_idx !== 6'd0 || done !== 1'b0) begin
      errors++; $display("FAIL stop_wins got busy %b idx %0d done %b want 0 0 0", busy, note_idx, done);
    end
    cyc();
    checks++; if (volumn !== 16'h8000 || busy !== 1'b0) begin
      errors++; $display("FAIL stop_idle got vol %h busy %b want 8000 0", volumn, busy);
    end
    play = 1; cyc(); play = 0;
    repeat (9) cyc();
    checks++; if (note_idx !== 6'd1) begin errors++; $display("FAIL stop_pre got %0d want 1", note_idx); end
    stop = 1; cyc(); stop = 0;
    checks++; if (note_idx !== 6'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL stop_mid got idx %0d busy %b want 0 0", note_idx, busy);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    vol_up = 1; cyc(); vol_up = 0;
    play = 1; cyc(); play = 0;
    repeat (14) cyc();
    checks++; if (note_div !== DIV3 || volumn !== 16'hD000) begin
      errors++; $display("FAIL arst_pre got div %0d vol %h want %0d d000", note_div, volumn, DIV3);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (note_div !== 20'd0 || volumn !== 16'h8000 || note_idx !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL arst_outputs got div %0d vol %h idx %0d busy %b done %b want reset values",
                         note_div, volumn, note_idx, busy, done);
    end
    #2 rst_n = 1'b1;
    cyc();
    play = 1; cyc(); play = 0;
    cyc();
    checks++; if (volumn !== 16'hC000) begin errors++; $display("FAIL arst_level got %h want c000", volumn); end
  endtask

  // Random pulses against a model that tracks cycles spent in the current note.
  task automatic test_random();
    int m_mode, m_idx, m_el, m_lvl, note_cycles;
    bit p, s, u, d;
    logic [19:0] e_div;
    logic [15:0] e_vol;
    logic        e_done;
    logic [43:0] got, expv;
    do_reset();
    m_mode = 0; m_idx = 0; m_el = 0; m_lvl = 4; e_div = 20'd0;
    for (int c = 0; c < 600; c++) begin
      p = ($urandom_range(9) == 0);
      s = ($urandom_range(59) == 0);
      u = ($urandom_range(7) == 0);
      d = ($urandom_range(7) == 0);
      play = p; stop = s; vol_up = u; vol_down = d;
      cyc();
      play = 0; stop = 0; vol_up = 0; vol_down = 0;
      // Outputs reflect the mode/note/level in force during the cycle just clocked.
      if (m_mode == 1) e_div = div_of(rom_code[m_idx]);
      e_vol = (m_mode == 1 && rom_code[m_idx] != 0) ? 16'(32768 + m_lvl * 4096) : 16'h8000;
      e_done = 1'b0;
      note_cycles = ((rom_len[m_idx] == 0) ? 1 : rom_len[m_idx]) * BD;
      if (s) begin
        m_mode = 0; m_idx = 0; m_el = 0;
      end else if (p) begin
        if (m_mode == 0) begin m_mode = 1; m_idx = 0; m_el = 0; end
        else if (m_mode == 1) m_mode = 2;
        else m_mode = 1;
      end else if (m_mode == 1) begin
        m_el++;
        if (m_el == note_cycles) begin
          m_el = 0;
          if (m_idx == LEN - 1) begin
            m_idx = 0; e_done = 1'b1;
            if (!LOOP) m_mode = 0;
          end else begin
            m_idx++;
          end
        end
      end
      if (u && !d && m_lvl < 7) m_lvl++;
      if (d && !u && m_lvl > 0) m_lvl--;
      got  = {note_div, volumn, note_idx, busy, done};
      expv = {e_div, e_vol, 6'(m_idx), (m_mode != 0), e_done};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL random c=%0d got div %0d vol %h idx %0d busy %b done %b want div %0d vol %h idx %0d busy %b done %b",
                 c, note_div, volumn, note_idx, busy, done, e_div, e_vol, m_idx, (m_mode != 0), e_done);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    play = 0; stop = 0; vol_up = 0; vol_down = 0;
    test_reset();
    test_song();
    test_pause();
    test_volume();
    test_stop_play();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a stored melody by stepping through a note ROM at a fixed beat rate. For each note it drives the pitch divider (`note_div`) and amplitude (`volumn`) consumed by `buzzer_control`, which sits directly downstream. Play/pause, stop and volume step controls come from debounced one-cycle pulses supplied by the board-input stage.

## Interface
- `BEAT_DIV`, default 12_500_000: clock cycles per beat (1/8 s at 100 MHz); must be ≥ 2.
- `SONG_LEN`, default 64: number of ROM entries played, 1..64.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `play` in 1: one-cycle pulse; start from IDLE, or toggle between PLAY and PAUSE.
- `stop` in 1: one-cycle pulse; return to IDLE and index 0.
- `vol_up` in 1: one-cycle pulse; volume level +1, saturating at 7.
- `vol_down` in 1: one-cycle pulse; volume level −1, saturating at 0.
- `note_div` out 20: divider for `buzzer_control`.
- `volumn` out 16: amplitude for `buzzer_control`.
- `note_idx` out 6: index of the current ROM entry.
- `busy` out 1: high in PLAY or PAUSE.
- `done` out 1: one-cycle pulse when the last note's final beat ends.

## Operation
- ROM entry is 8 bits: [7:3] pitch code (0 = rest), [2:0] length in beats.
  - Length 0 is treated as 1.
- Pitch code maps to a 20-bit divider through a constant table. Unused codes map to rest.
- Volume level is 3 bits. Reset value is 4.
  - `vol_up` and `vol_down` in the same cycle: no change.
  - Volume pulses act in every state.
- Amplitude rule: `volumn = 16'h8000 + {level, 12'h000}`.
  - Level 0 gives 16'h8000, which is silent downstream.
  - `volumn` is forced to 16'h8000 on a rest, in IDLE, and in PAUSE.
- States:
  - IDLE: `play` → PLAY, index 0, beat and length counters cleared.
  - PLAY: `play` → PAUSE. Beat and length counters freeze; `note_idx` and `note_div` hold.
  - PAUSE: `play` → PLAY, resuming the same beat count.
  - Any state: `stop` → IDLE. `stop` wins over `play` in the same cycle.
- Beat counter runs 0..BEAT_DIV−1 in PLAY only. Its terminal count is a beat tick.
- The length counter counts beat ticks. When it reaches the note's length, the index advances.
- End of song (index SONG_LEN−1, final beat tick):
  - `done` pulses for one cycle.
  - Behaviour after that is set by the configuration macro.
- All outputs are registered.
- Reset values:
  - state IDLE, `note_idx` 0, `note_div` 0, `volumn` 16'h8000, `busy` 0, `done` 0.
  - Level 4, all counters 0.
- Reset asserted mid-play returns immediately to these values.

## Timing
- `play` pulse in IDLE at cycle n:
  - cycle n+1: state PLAY, `busy`=1.
  - cycle n+2: `note_div` and `volumn` carry note 0.
- Note advance: the beat tick at cycle t updates `note_idx` at t+1, and `note_div`/`volumn` at t+2.
- A note of L beats lasts exactly L·BEAT_DIV cycles while in PLAY.
- A volume pulse at cycle n changes `volumn` at n+2.
- `done` is asserted in the same cycle `note_idx` wraps or the state enters IDLE.

## Configuration
- `MELODY_LOOP_EN` defined:
  - At end of song, index wraps to 0 and the state stays PLAY.
  - `done` still pulses on every wrap.
- `MELODY_LOOP_EN` undefined:
  - At end of song, the state goes to IDLE with index 0.
  - `note_div` holds its last value; `volumn` becomes 16'h8000.

## Structure
- Shared package `melody_pkg` holds:
  - State encodings: IDLE=2'd0, PLAY=2'd1, PAUSE=2'd2.
  - Pitch-code constants and the pitch→divider function.
  - Silence constant 16'h8000.
  - Volume step constant.
- Sub-module `melody_rom`: combinational 6-bit address → 8-bit entry. It holds the song data only.

## Test plan
Bench uses BEAT_DIV=4, SONG_LEN=3 and ROM {code 1 len 2, rest len 1, code 3 len 0}.
- Reset, then `play` at cycle 10:
  - `busy`=1 at cycle 11.
  - `note_div`=div(1) and `volumn`=16'hC000 at cycle 12.
  - Note 0 holds 8 cycles.
- Note 1 (rest): `volumn`=16'h8000 for 4 cycles. Note 2 (length 0) lasts 4 cycles.
- Song end:
  - Loop undefined: one-cycle `done`, then IDLE with `busy`=0.
  - Loop defined: `done`, `note_idx`=0, and note 0 replays.
- `play` during note 0 at beat count 2:
  - `volumn`=16'h8000 and counters frozen for 20 cycles.
  - A second `play` resumes; note 0 ends after the remaining 6 cycles of play.
- Volume saturation:
  - 5× `vol_up` → 16'hF000.
  - 9× `vol_down` → 16'h8000.
  - `vol_up` and `vol_down` in the same cycle → unchanged.
- Mid-play conditions:
  - `stop` and `play` in the same cycle → IDLE.
  - `rst_n` low mid-note → all outputs at reset values asynchronously, before the next clk edge.
